// File: rtl/dii_buffer.sv
// DII channel FIFO with optional store-and-forward (FULLPACKET) mode.
// Define DII_BUFFER_FRAMING_CHECK_EN to add the first/last framing checker and err_framing port.
module dii_buffer #(
  parameter int WIDTH      = 16,
  parameter int SIZE       = 8,
  parameter int FULLPACKET = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DII_BUFFER_FRAMING_CHECK_EN
  ,
  output logic             err_framing
`endif
);

  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;

  logic [WIDTH+1:0] mem_q [SIZE];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic             forced_q, forced_d;
  logic             empty, full, wr_en, rd_en, out_avail;
  logic [WIDTH+1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // In store-and-forward mode a full buffer releases an oversized packet as cut-through.
  always_comb begin
    out_avail = !empty;
    if (FULLPACKET != 0) begin
      out_avail = !empty && ((pkt_cnt_q != '0) || full || forced_q);
    end
  end

  assign in_ready  = !full;
  assign wr_en     = in_valid && !full;
  assign rd_en     = out_avail && out_ready;
  assign out_valid = out_avail;
  assign out_data  = out_avail ? head[WIDTH-1:0] : '0;
  assign out_first = out_avail && head[WIDTH+1];
  assign out_last  = out_avail && head[WIDTH];

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(wr_en);
    rd_ptr_d  = rd_ptr_q + PW'(rd_en);
    pkt_cnt_d = pkt_cnt_q;
    case ({wr_en && in_last, rd_en && head[WIDTH]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    forced_d = forced_q;
    if (rd_en) begin
      if (head[WIDTH]) begin
        forced_d = 1'b0;
      end else if (pkt_cnt_q == '0) begin
        forced_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      forced_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      forced_q  <= forced_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_first, in_last, in_data};
    end
  end

`ifdef DII_BUFFER_FRAMING_CHECK_EN
  typedef enum logic {FR_IDLE, FR_INPKT} fr_state_e;

  fr_state_e fr_state_q;
  logic      err_framing_q;

  // Checks only flits actually accepted; the error is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_state_q    <= FR_IDLE;
      err_framing_q <= 1'b0;
    end else if (wr_en) begin
      case (fr_state_q)
        FR_IDLE: begin
          if (!in_first) begin
            err_framing_q <= 1'b1;
          end else if (!in_last) begin
            fr_state_q <= FR_INPKT;
          end
        end
        FR_INPKT: begin
          if (in_first) begin
            err_framing_q <= 1'b1;
          end else if (in_last) begin
            fr_state_q <= FR_IDLE;
          end
        end
        default: fr_state_q <= FR_IDLE;
      endcase
    end
  end

  assign err_framing = err_framing_q;
`endif

endmodule

// File: tb/tb_dii_buffer.sv
// Scoreboard bench for dii_buffer: one cut-through instance and one store-and-forward instance.
module tb_dii_buffer;

  logic        clk;
  logic        rst_n;

  logic [15:0] in_data0, out_data0, in_data1, out_data1;
  logic        in_first0, in_last0, in_valid0, in_ready0;
  logic        out_first0, out_last0, out_valid0, out_ready0;
  logic        in_first1, in_last1, in_valid1, in_ready1;
  logic        out_first1, out_last1, out_valid1, out_ready1;
`ifdef DII_BUFFER_FRAMING_CHECK_EN
  logic        err_framing0, err_framing1;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [17:0] exp0[$];
  logic [17:0] exp1[$];
  logic [17:0] mon0_exp, mon1_exp;
  logic        ok;

  dii_buffer #(.WIDTH(16), .SIZE(8), .FULLPACKET(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data0), .in_first(in_first0), .in_last(in_last0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_first(out_first0), .out_last(out_last0),
    .out_valid(out_valid0), .out_ready(out_ready0)
`ifdef DII_BUFFER_FRAMING_CHECK_EN
    , .err_framing(err_framing0)
`endif
  );

  dii_buffer #(.WIDTH(16), .SIZE(8), .FULLPACKET(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data1), .in_first(in_first1), .in_last(in_last1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_first(out_first1), .out_last(out_last1),
    .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef DII_BUFFER_FRAMING_CHECK_EN
    , .err_framing(err_framing1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Drives one flit into the selected instance, retrying until accepted or maxWait cycles pass.
  task automatic applyStimulus(input int port, input logic [15:0] d, input logic f, input logic l,
                               input int maxWait, output logic accepted);
    int n;
    accepted = 1'b0;
    if (port == 0) begin
      in_data0 = d; in_first0 = f; in_last0 = l; in_valid0 = 1'b1;
    end else begin
      in_data1 = d; in_first1 = f; in_last1 = l; in_valid1 = 1'b1;
    end
    n = 0;
    while (!accepted && n < maxWait) begin
      @(negedge clk);
      if ((port == 0) ? in_ready0 : in_ready1) begin
        accepted = 1'b1;
        if (port == 0) exp0.push_back({f, l, d});
        else           exp1.push_back({f, l, d});
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (port == 0) in_valid0 = 1'b0;
    else           in_valid1 = 1'b0;
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout port%0d: got no accept expected accept of %0h", port, d);
    end
  endtask

  task automatic drainWait(input int port, input int maxCycles);
    int n;
    n = 0;
    while (((port == 0) ? exp0.size() : exp1.size()) != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    if (((port == 0) ? exp0.size() : exp1.size()) != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain port%0d: got %0d flits outstanding expected 0", port,
               (port == 0) ? exp0.size() : exp1.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready0) begin
      total++;
      if (exp0.size() == 0) begin
        bad++;
        $display("[TB] FAIL mon0_extra: got %0h expected no flit", {out_first0, out_last0, out_data0});
      end else begin
        mon0_exp = exp0.pop_front();
        if ({out_first0, out_last0, out_data0} !== mon0_exp) begin
          bad++;
          $display("[TB] FAIL mon0_flit: got %0h expected %0h", {out_first0, out_last0, out_data0}, mon0_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      total++;
      if (exp1.size() == 0) begin
        bad++;
        $display("[TB] FAIL mon1_extra: got %0h expected no flit", {out_first1, out_last1, out_data1});
      end else begin
        mon1_exp = exp1.pop_front();
        if ({out_first1, out_last1, out_data1} !== mon1_exp) begin
          bad++;
          $display("[TB] FAIL mon1_flit: got %0h expected %0h", {out_first1, out_last1, out_data1}, mon1_exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_data0 = '0; in_first0 = 0; in_last0 = 0; in_valid0 = 0; out_ready0 = 0;
    in_data1 = '0; in_first1 = 0; in_last1 = 0; in_valid1 = 0; out_ready1 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready0", in_ready0, 1);
    checkOutput("rst_out_valid0", out_valid0, 0);
    checkOutput("rst_out_data0", out_data0, 0);
    checkOutput("rst_in_ready1", in_ready1, 1);
    checkOutput("rst_out_valid1", out_valid1, 0);
    checkOutput("rst_out_first1", out_first1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming 20 flits through the cut-through buffer
    $display("[TB] streaming test");
    out_ready0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data0  = 16'h0100 + 16'(i);
      in_first0 = (i % 4 == 0);
      in_last0  = (i % 4 == 3);
      in_valid0 = 1'b1;
      exp0.push_back({in_first0, in_last0, in_data0});
      @(negedge clk);
      checkOutput("stream_in_ready", in_ready0, 1);
      if (i > 0) begin
        checkOutput("stream_latency_valid", out_valid0, 1);
        checkOutput("stream_latency_data", out_data0, 32'h0100 + 32'(i - 1));
      end
      @(posedge clk);
      #1;
    end
    in_valid0 = 1'b0;
    drainWait(0, 10);
    checkOutput("stream_idle_valid", out_valid0, 0);

    // Fill to full with the output stalled
    $display("[TB] backpressure test");
    out_ready0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 16'(i), 1'b1, 1'b1, 3, ok);
      if (i == 7) checkOutput("bp_in_ready_at7", in_ready0, 1);
    end
    checkOutput("bp_in_ready_full", in_ready0, 0);
    checkOutput("bp_head_data", out_data0, 16'h0001);
    in_data0 = 16'h0009; in_first0 = 1; in_last0 = 1; in_valid0 = 1'b1;
    out_ready0 = 1'b1;
    @(negedge clk);
    checkOutput("bp_push_while_full", in_ready0, 0);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    drainWait(0, 20);
    checkOutput("bp_drained_valid", out_valid0, 0);

    // Store-and-forward: 3-flit packet with gaps
    $display("[TB] fullpacket short packet test");
    out_ready1 = 1'b1;
    applyStimulus(1, 16'h0A01, 1'b1, 1'b0, 3, ok);
    @(negedge clk);
    checkOutput("fp_hold_f1", out_valid1, 0);
    @(posedge clk);
    #1;
    applyStimulus(1, 16'h0A02, 1'b0, 1'b0, 3, ok);
    @(negedge clk);
    checkOutput("fp_hold_f2", out_valid1, 0);
    @(posedge clk);
    #1;
    applyStimulus(1, 16'h0A03, 1'b0, 1'b1, 3, ok);
    @(negedge clk);
    checkOutput("fp_release_valid", out_valid1, 1);
    checkOutput("fp_release_first", out_first1, 1);
    @(negedge clk);
    checkOutput("fp_b2b_valid2", out_valid1, 1);
    @(negedge clk);
    checkOutput("fp_b2b_valid3", out_valid1, 1);
    checkOutput("fp_b2b_last", out_last1, 1);
    @(negedge clk);
    checkOutput("fp_after_pkt_valid", out_valid1, 0);
    @(posedge clk);
    #1;

    // Store-and-forward: 12-flit packet exceeds the depth and must cut through
    $display("[TB] fullpacket oversized packet test");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 16'h0C00 + 16'(i), (i == 0), (i == 11), 50, ok);
    end
    drainWait(1, 100);
    checkOutput("fp_long_idle_valid", out_valid1, 0);
    applyStimulus(1, 16'h0D00, 1'b1, 1'b0, 3, ok);
    @(negedge clk);
    checkOutput("fp_cnt_cleared_hold", out_valid1, 0);
    @(posedge clk);
    #1;
    applyStimulus(1, 16'h0D01, 1'b0, 1'b1, 3, ok);
    drainWait(1, 10);

`ifdef DII_BUFFER_FRAMING_CHECK_EN
    checkOutput("frame_clean0", err_framing0, 0);
    checkOutput("frame_clean1", err_framing1, 0);
`endif

    // Asynchronous reset with a partial packet stored
    $display("[TB] mid-packet reset test");
    out_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 16'h0500 + 16'(i), (i == 0), 1'b0, 3, ok);
    end
    @(negedge clk);
    checkOutput("mid_pre_valid", out_valid0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_async_valid", out_valid0, 0);
    checkOutput("mid_async_ready", in_ready0, 1);
    checkOutput("mid_async_data", out_data0, 0);
    exp0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready0 = 1'b1;
    applyStimulus(0, 16'h0600, 1'b1, 1'b0, 3, ok);
    @(negedge clk);
    checkOutput("post_rst_data", out_data0, 16'h0600);
    @(posedge clk);
    #1;
    applyStimulus(0, 16'h0601, 1'b0, 1'b1, 3, ok);
    drainWait(0, 10);
    checkOutput("post_rst_idle", out_valid0, 0);

`ifdef DII_BUFFER_FRAMING_CHECK_EN
    $display("[TB] framing checker test");
    checkOutput("frame_before", err_framing0, 0);
    applyStimulus(0, 16'h0777, 1'b0, 1'b1, 3, ok);
    @(negedge clk);
    checkOutput("frame_set", err_framing0, 1);
    checkOutput("frame_data_fwd", out_data0, 16'h0777);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("frame_sticky", err_framing0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("frame_cleared", err_framing0, 0);
    exp0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
